// File: rtl/global_mem_arbiter.sv
// Per-bank round-robin arbiter between N_PORTS requesters and N_BANKS global memory banks.
// Optional bank-conflict counter is enabled by defining GLOBAL_MEM_ARB_CONFLICT_CNT_EN.
module global_mem_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int N_BANKS     = 4,
  parameter int BANK_ADDR_L = 8,
  parameter int RD_LATENCY  = 2,
  parameter int DATA_L      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              req,
  input  logic [N_PORTS-1:0]              req_we,
  input  logic [N_PORTS*(BANK_ADDR_L+$clog2(N_BANKS))-1:0] req_addr,
  input  logic [N_PORTS*DATA_L-1:0]       req_wr_data,
  output logic [N_PORTS-1:0]              gnt,
  output logic [N_PORTS-1:0]              rsp_valid,
  output logic [N_PORTS*DATA_L-1:0]       rsp_data,
  output logic [N_BANKS*BANK_ADDR_L-1:0]  global_mem_addr,
  output logic [N_BANKS*DATA_L-1:0]       global_mem_wr_data,
  output logic [N_BANKS-1:0]              global_mem_wr_en,
  output logic [N_BANKS-1:0]              global_mem_rd_en,
  input  logic [N_BANKS*DATA_L-1:0]       global_mem_rd_data,
  output logic [31:0]                     conflict_cnt
);
  localparam int SEL_L  = $clog2(N_BANKS);
  localparam int ADDR_L = BANK_ADDR_L + SEL_L;
  localparam int PID_L  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  // Handshake: req/req_we/req_addr/req_wr_data stay stable until gnt is seen high in
  // the same cycle; gnt is combinational and the access is launched to the bank that cycle.
  logic [PID_L-1:0]   rr_ptr  [N_BANKS];
  logic [N_BANKS-1:0] bank_hit;
  logic [PID_L-1:0]   bank_id [N_BANKS];
  logic [RD_LATENCY-1:0] sh_vld [N_BANKS];
  logic [PID_L-1:0]      sh_id  [N_BANKS][RD_LATENCY];

  always_comb begin
    int idx;
    int p;
    idx                = 0;
    p                  = 0;
    bank_hit           = '0;
    gnt                = '0;
    global_mem_addr    = '0;
    global_mem_wr_data = '0;
    global_mem_wr_en   = '0;
    global_mem_rd_en   = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      bank_id[b] = '0;
    end
    if (rst) begin
      for (int b = 0; b < N_BANKS; b++) begin
        for (int k = 0; k < N_PORTS; k++) begin
          idx = (int'(rr_ptr[b]) + k) % N_PORTS;
          if (!bank_hit[b] && req[idx] &&
              req_addr[idx*ADDR_L +: SEL_L] == SEL_L'(b)) begin
            bank_hit[b] = 1'b1;
            bank_id[b]  = PID_L'(idx);
          end
        end
        if (bank_hit[b]) begin
          p = int'(bank_id[b]);
          gnt[p] = 1'b1;
          global_mem_addr[b*BANK_ADDR_L +: BANK_ADDR_L] = req_addr[p*ADDR_L+SEL_L +: BANK_ADDR_L];
          global_mem_wr_data[b*DATA_L +: DATA_L]        = req_wr_data[p*DATA_L +: DATA_L];
          global_mem_wr_en[b] = req_we[p];
          global_mem_rd_en[b] = ~req_we[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < N_BANKS; b++) begin
        rr_ptr[b] <= '0;
        sh_vld[b] <= '0;
        for (int s = 0; s < RD_LATENCY; s++) sh_id[b][s] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (bank_hit[b]) rr_ptr[b] <= PID_L'((int'(bank_id[b]) + 1) % N_PORTS);
        for (int s = RD_LATENCY - 1; s > 0; s--) begin
          sh_vld[b][s] <= sh_vld[b][s-1];
          sh_id[b][s]  <= sh_id[b][s-1];
        end
        sh_vld[b][0] <= global_mem_rd_en[b];
        sh_id[b][0]  <= bank_id[b];
      end
    end
  end

  // The tail of each bank's pipeline lines up with that bank's read data.
  always_comb begin
    int p;
    p         = 0;
    rsp_valid = '0;
    rsp_data  = '0;
    if (rst) begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (sh_vld[b][RD_LATENCY-1]) begin
          p = int'(sh_id[b][RD_LATENCY-1]);
          rsp_valid[p] = 1'b1;
          rsp_data[p*DATA_L +: DATA_L] = global_mem_rd_data[b*DATA_L +: DATA_L];
        end
      end
    end
  end

`ifdef GLOBAL_MEM_ARB_CONFLICT_CNT_EN
  localparam int MISS_L = $clog2(N_PORTS + 1);
  logic [MISS_L-1:0] miss;
  logic [32:0]       cnt_sum;

  always_comb begin
    miss = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      miss = miss + MISS_L'(req[p] & ~gnt[p]);
    end
    cnt_sum = {1'b0, conflict_cnt} + 33'(miss);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else begin
      conflict_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end
  end
`else
  assign conflict_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Directed bench for global_mem_arbiter with a bank memory model and a response scoreboard.
// Conflict-counter expectations follow GLOBAL_MEM_ARB_CONFLICT_CNT_EN.
module tb_global_mem_arbiter;
  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int BAL = 8;
  localparam int RDL = 2;
  localparam int DL  = 32;
  localparam int AL  = BAL + 2;
  localparam int EXP_W = 66;
`ifdef GLOBAL_MEM_ARB_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req, req_we, gnt, rsp_valid;
  logic [NP*AL-1:0]  req_addr;
  logic [NP*DL-1:0]  req_wr_data, rsp_data;
  logic [NB*BAL-1:0] global_mem_addr;
  logic [NB*DL-1:0]  global_mem_wr_data, global_mem_rd_data;
  logic [NB-1:0]     global_mem_wr_en, global_mem_rd_en;
  logic [31:0]       conflict_cnt;

  global_mem_arbiter #(.N_PORTS(NP), .N_BANKS(NB), .BANK_ADDR_L(BAL),
                       .RD_LATENCY(RDL), .DATA_L(DL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .global_mem_addr(global_mem_addr), .global_mem_wr_data(global_mem_wr_data),
    .global_mem_wr_en(global_mem_wr_en), .global_mem_rd_en(global_mem_rd_en),
    .global_mem_rd_data(global_mem_rd_data), .conflict_cnt(conflict_cnt)
  );

  // clock / reset / cycle count
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [31:0] init_val(int b, int a);
    return 32'hC0DE_0000 | 32'(b << 8) | 32'(a);
  endfunction

  // bank memory model with RDL-cycle read latency
  logic [31:0] mem  [NB][256];
  logic [31:0] pipe [NB][RDL];
  bit mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 256; a++) mem[b][a] <= init_val(b, a);
      mem_ready <= 1'b1;
    end else begin
      for (int b = 0; b < NB; b++)
        if (global_mem_wr_en[b]) mem[b][global_mem_addr[b*BAL +: BAL]] <= global_mem_wr_data[b*DL +: DL];
    end
    for (int b = 0; b < NB; b++) begin
      pipe[b][0] <= global_mem_rd_en[b] ? mem[b][global_mem_addr[b*BAL +: BAL]] : 32'h0;
      for (int s = 1; s < RDL; s++) pipe[b][s] <= pipe[b][s-1];
    end
  end

  always_comb begin
    for (int b = 0; b < NB; b++) global_mem_rd_data[b*DL +: DL] = pipe[b][RDL-1];
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, bit r, bit we, int addr, logic [31:0] d);
    req[p]    = r;
    req_we[p] = we;
    req_addr[p*AL +: AL]    = AL'(addr);
    req_wr_data[p*DL +: DL] = d;
  endtask

  task automatic clear_ports();
    req = '0; req_we = '0; req_addr = '0; req_wr_data = '0;
  endtask

  task automatic expect_rsp(int p, logic [31:0] d);
    exp_q.push_back({32'(cyc + RDL), 2'(p), d});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rsp_valid[p]) begin
        int hit;
        hit = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (hit < 0 && exp_q[i][65:34] == 32'(cyc) && exp_q[i][33:32] == 2'(p)) hit = i;
        if (hit < 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_rsp port %0d: got data 0x%0h, expected no response (cycle %0d)",
                   p, rsp_data[p*DL +: DL], cyc);
        end else begin
          check($sformatf("rsp_data_p%0d", p), 64'(rsp_data[p*DL +: DL]), 64'(exp_q[hit][31:0]));
          exp_q.delete(hit);
        end
      end else begin
        check($sformatf("rsp_idle_zero_p%0d", p), 64'(rsp_data[p*DL +: DL]), 64'h0);
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][65:34] < 32'(cyc)) begin
        tests++;
        failed++;
        $display("FAIL missing_rsp port %0d: got no response, expected data 0x%0h at cycle %0d",
                 exp_q[i][33:32], exp_q[i][31:0], exp_q[i][65:34]);
        exp_q.delete(i);
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b0;
    clear_ports();
    set_port(0, 1, 1, 5, 32'hAB);
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_wr_en", 64'(global_mem_wr_en), 64'h0);
    check("rst_rd_en", 64'(global_mem_rd_en), 64'h0);
    check("rst_addr", 64'(global_mem_addr), 64'h0);
    check("rst_wr_data", 64'(global_mem_wr_data[63:0]), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_conflict", 64'(conflict_cnt), 64'h0);
    step();

    // all four ports read bank 1 continuously
    rst = 1'b1;
    clear_ports();
    for (int p = 0; p < NP; p++) set_port(p, 1, 0, ((p + 2) << 2) | 1, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("rr_gnt_%0d", k), 64'(gnt), 64'(1 << (k % 4)));
      check($sformatf("rr_conflict_%0d", k), 64'(conflict_cnt), CNT_EN ? 64'(3 * k) : 64'h0);
      expect_rsp(k % 4, init_val(1, (k % 4) + 2));
      step();
    end
    clear_ports();

    // write 0xAB to addr 5, then read it back
    set_port(0, 1, 1, 5, 32'hAB);
    @(negedge clk);
    check("wr_gnt", 64'(gnt), 64'h1);
    check("wr_en", 64'(global_mem_wr_en), 64'h2);
    check("wr_rd_en", 64'(global_mem_rd_en), 64'h0);
    check("wr_addr", 64'(global_mem_addr[BAL +: BAL]), 64'h1);
    check("wr_data", 64'(global_mem_wr_data[DL +: DL]), 64'hAB);
    step();
    set_port(0, 1, 0, 5, 32'h0);
    @(negedge clk);
    check("rd_gnt", 64'(gnt), 64'h1);
    check("rd_en", 64'(global_mem_rd_en), 64'h2);
    expect_rsp(0, 32'hAB);
    step();
    clear_ports();

    // distinct banks: all granted together
    for (int p = 0; p < NP; p++) set_port(p, 1, 0, (7 << 2) | p, 32'h0);
    @(negedge clk);
    check("par_gnt", 64'(gnt), 64'hF);
    check("par_rd_en", 64'(global_mem_rd_en), 64'hF);
    for (int p = 0; p < NP; p++) expect_rsp(p, init_val(p, 7));
    step();
    clear_ports();
    repeat (3) step();

    // reset one cycle after a read grant discards it and clears rr_ptr
    set_port(1, 1, 0, (3 << 2) | 2, 32'h0);
    @(negedge clk);
    check("flush_gnt", 64'(gnt), 64'h2);
    step();
    clear_ports();
    rst = 1'b0;
    @(negedge clk);
    check("flush_rsp_valid", 64'(rsp_valid), 64'h0);
    step();
    @(negedge clk);
    check("flush_rsp_valid2", 64'(rsp_valid), 64'h0);
    step();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1, 1, (p << 2) | 1, 32'(p));
    @(negedge clk);
    check("post_rst_gnt", 64'(gnt), 64'h1);
    step();
    clear_ports();
    repeat (3) step();

    // write/read same address on bank 0 with rr_ptr[0] = 3
    set_port(2, 1, 1, 10 << 2, 32'h11);
    @(negedge clk);
    check("setup_gnt", 64'(gnt), 64'h4);
    step();
    set_port(2, 1, 1, 9 << 2, 32'h55);
    set_port(3, 1, 0, 9 << 2, 32'h0);
    @(negedge clk);
    check("wr_rd_gnt_p3", 64'(gnt), 64'h8);
    check("wr_rd_rd_en", 64'(global_mem_rd_en), 64'h1);
    check("wr_rd_wr_en0", 64'(global_mem_wr_en), 64'h0);
    expect_rsp(3, init_val(0, 9));
    step();
    set_port(3, 0, 0, 0, 32'h0);
    @(negedge clk);
    check("wr_rd_gnt_p2", 64'(gnt), 64'h4);
    check("wr_rd_wr_en1", 64'(global_mem_wr_en), 64'h1);
    check("wr_rd_wr_data", 64'(global_mem_wr_data[DL-1:0]), 64'h55);
    step();
    clear_ports();
    set_port(0, 1, 0, 9 << 2, 32'h0);
    @(negedge clk);
    check("readback_gnt", 64'(gnt), 64'h1);
    expect_rsp(0, 32'h55);
    step();
    clear_ports();
    repeat (4) step();

    @(negedge clk);
    check("drain_queue", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
